// File: rtl/seg_capture_if.sv
// rtl/seg_capture_if.sv - decoded-digit output stream between seg_capture and its consumer
interface seg_capture_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_nibble;
  logic       out_err;
  logic [6:0] out_raw;

  modport master (
    output out_valid,
    output out_nibble,
    output out_err,
    output out_raw,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_nibble,
    input  out_err,
    input  out_raw,
    output out_ready
  );
endinterface

// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - seven-segment observer: debounce, decode, dedupe and queue digits
module seg_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [6:0]    segments,
  seg_capture_if.master out,
  output logic [4:0]    count,
  output logic          overflow
);

  localparam int         AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] STABLE_MAX = 4'(STABLE_CYCLES);
  localparam logic [3:0] STABLE_PRE = 4'(STABLE_CYCLES - 1);
  localparam logic [4:0] DEPTH      = 5'(FIFO_DEPTH);

  typedef struct packed {
    logic [6:0] raw;
    logic       err;
    logic [3:0] nibble;
  } entry_t;

  // sample_q is the registered previous sample; the incoming pattern is only
  // ever compared against it, so nothing on the output side sees segments
  // without passing through a register.
  logic [6:0]    sample_q;
  logic [6:0]    last_q, last_d;
  logic [3:0]    stab_q, stab_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [4:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  entry_t        mem_q [FIFO_DEPTH];

  entry_t        head;
  entry_t        new_entry;
  logic          same;
  logic          accept;
  logic          push_req;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic [3:0]    dec_nib;
  logic          dec_ok;

  // Hex decode of the pattern being accepted; anything off the table is an error entry.
  always_comb begin
    dec_ok  = 1'b1;
    dec_nib = 4'h0;
    case (segments)
      7'h3F:   dec_nib = 4'h0;
      7'h06:   dec_nib = 4'h1;
      7'h5B:   dec_nib = 4'h2;
      7'h4F:   dec_nib = 4'h3;
      7'h66:   dec_nib = 4'h4;
      7'h6D:   dec_nib = 4'h5;
      7'h7D:   dec_nib = 4'h6;
      7'h07:   dec_nib = 4'h7;
      7'h7F:   dec_nib = 4'h8;
      7'h6F:   dec_nib = 4'h9;
      7'h77:   dec_nib = 4'hA;
      7'h7C:   dec_nib = 4'hB;
      7'h39:   dec_nib = 4'hC;
      7'h5E:   dec_nib = 4'hD;
      7'h79:   dec_nib = 4'hE;
      7'h71:   dec_nib = 4'hF;
      default: dec_ok  = 1'b0;
    endcase
  end

  // Stability tracking, dedupe against the last accepted pattern, and FIFO bookkeeping.
  always_comb begin
    same = (segments == sample_q);

    // Acceptance fires on the single transition into saturation, so a long
    // stable run produces exactly one accept.
    accept = same && (stab_q == STABLE_PRE);
    if (!same) begin
      stab_d = 4'd0;
    end else if (stab_q == STABLE_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 4'd1;
    end

    // Blank is remembered as last-accepted so the same digit can reappear
    // after the display goes dark.
    push_req = accept && (segments != 7'h00) && (segments != last_q);
    last_d   = accept ? segments : last_q;

    full = (count_q == DEPTH);
    pop  = (count_q != 5'd0) && out.out_ready;
    push = push_req && (!full || pop);
    drop = push_req && full && !pop;

    wr_d    = push ? wr_q + AW'(1) : wr_q;
    rd_d    = pop  ? rd_q + AW'(1) : rd_q;
    count_d = count_q + 5'(push) - 5'(pop);
    ovf_d   = ovf_q | drop;

    new_entry.raw    = segments;
    new_entry.err    = !dec_ok;
    new_entry.nibble = dec_ok ? dec_nib : 4'h0;
  end

  // State update; storage cells are not reset since count_q gates their visibility.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= 7'h00;
      last_q   <= 7'h00;
      stab_q   <= 4'd0;
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      sample_q <= segments;
      last_q   <= last_d;
      stab_q   <= stab_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      if (push) begin
        mem_q[wr_q] <= new_entry;
      end
    end
  end

  assign head           = mem_q[rd_q];
  assign out.out_valid  = (count_q != 5'd0);
  assign out.out_raw    = out.out_valid ? head.raw    : 7'h00;
  assign out.out_err    = out.out_valid ? head.err    : 1'b0;
  assign out.out_nibble = out.out_valid ? head.nibble : 4'h0;
  assign count          = count_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed and randomized checks of seg_capture against a queue model
module tb_seg_capture;
  localparam int S = 4;
  localparam int D = 8;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic [6:0] segments = 7'h00;
  logic [4:0] count;
  logic       overflow;

  seg_capture_if bus ();

  seg_capture #(.STABLE_CYCLES(S), .FIFO_DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .segments (segments),
    .out      (bus),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] m_q [$];
  logic [11:0] got [$];
  logic [6:0]  m_prev = 7'h00;
  logic [6:0]  m_last = 7'h00;
  int          m_match = 0;
  bit          m_ovf   = 1'b0;

  logic [6:0] digit_pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [6:0] pool [19] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                            7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h00, 7'h2A, 7'h49};

  function automatic logic [11:0] ref_entry(input logic [6:0] p);
    for (int i = 0; i < 16; i++) begin
      if (digit_pat[i] == p) return {p, 1'b0, 4'(i)};
    end
    return {p, 1'b1, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] got_at(input int i);
    return (got.size() > i) ? got[i] : 12'hFFF;
  endfunction

  // One clock: drive at the falling edge, advance the model at the rising edge,
  // compare at the next falling edge.
  task automatic tick(input logic [6:0] seg, input logic rdy, input logic r);
    logic [11:0] e;
    logic        acc;
    logic        do_pop;
    segments      = seg;
    bus.out_ready = rdy;
    rst           = r;
    #1;
    if (!r && bus.out_valid && rdy) got.push_back({bus.out_raw, bus.out_err, bus.out_nibble});
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_ovf   = 1'b0;
      m_prev  = 7'h00;
      m_last  = 7'h00;
      m_match = 0;
    end else begin
      do_pop = (m_q.size() > 0) && rdy;
      acc    = 1'b0;
      if (seg == m_prev) begin
        if (m_match < 1000) m_match++;
        if (m_match == S) acc = 1'b1;
      end else begin
        m_match = 0;
      end
      m_prev = seg;
      if (do_pop) void'(m_q.pop_front());
      if (acc) begin
        if (seg == 7'h00) begin
          m_last = 7'h00;
        end else if (seg != m_last) begin
          m_last = seg;
          if (m_q.size() < D) m_q.push_back(ref_entry(seg));
          else m_ovf = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("count", 32'(count), 32'(m_q.size()));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (m_q.size() > 0) begin
      e = m_q[0];
      check("head_raw", 32'(bus.out_raw), 32'(e[11:5]));
      check("head_err", 32'(bus.out_err), 32'(e[4]));
      check("head_nibble", 32'(bus.out_nibble), 32'(e[3:0]));
    end
  endtask

  task automatic hold(input logic [6:0] seg, input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(seg, rdy, 1'b0);
  endtask

  initial begin
    int         first;
    int         left;
    int         thr;
    logic [6:0] cur;
    bus.out_ready = 1'b0;

    // Reset state
    tick(7'h00, 1'b1, 1'b1);
    tick(7'h00, 1'b1, 1'b1);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_nibble", 32'(bus.out_nibble), 32'd0);
    check("rst_err", 32'(bus.out_err), 32'd0);
    check("rst_raw", 32'(bus.out_raw), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // 5B held 10 cycles: latency and single entry
    got.delete();
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(7'h5B, 1'b1, 1'b0);
      if (first == 0 && bus.out_valid) first = i;
    end
    check("latency_5B", 32'(first), 32'(S + 1));
    check("n_5B", 32'(got.size()), 32'd1);
    check("entry_5B", 32'(got_at(0)), 32'({7'h5B, 1'b0, 4'h2}));

    // Short 06 glitch followed by stable 4F
    got.delete();
    hold(7'h06, 3, 1'b1);
    hold(7'h4F, 8, 1'b1);
    check("n_glitch", 32'(got.size()), 32'd1);
    check("entry_4F", 32'(got_at(0)), 32'({7'h4F, 1'b0, 4'h3}));

    // 3F, blank, 3F, 3F continued: blank re-arms the same digit once
    got.delete();
    hold(7'h3F, 6, 1'b1);
    hold(7'h00, 6, 1'b1);
    hold(7'h3F, 6, 1'b1);
    hold(7'h3F, 6, 1'b1);
    check("n_3F", 32'(got.size()), 32'd2);
    check("entry_3F_a", 32'(got_at(0)), 32'({7'h3F, 1'b0, 4'h0}));
    check("entry_3F_b", 32'(got_at(1)), 32'({7'h3F, 1'b0, 4'h0}));

    // Non-hex pattern
    got.delete();
    hold(7'h2A, 8, 1'b1);
    check("n_2A", 32'(got.size()), 32'd1);
    check("entry_2A", 32'(got_at(0)), 32'({7'h2A, 1'b1, 4'h0}));

    // Nine digits into an eight-deep FIFO with no consumer
    got.delete();
    for (int d = 0; d < 9; d++) hold(digit_pat[d], 6, 1'b0);
    check("full_count", 32'(count), 32'(D));
    check("full_overflow", 32'(overflow), 32'd1);
    hold(7'h7F, 10, 1'b1);
    check("drain_n", 32'(got.size()), 32'(D));
    for (int d = 0; d < D; d++) check("drain_order", 32'(got_at(d)), 32'({digit_pat[d], 1'b0, 4'(d)}));
    check("drain_count", 32'(count), 32'd0);

    // Push and pop together while full
    tick(7'h00, 1'b0, 1'b1);
    for (int d = 0; d < D; d++) hold(digit_pat[d], 6, 1'b0);
    hold(7'h6F, 4, 1'b0);
    tick(7'h6F, 1'b1, 1'b0);
    tick(7'h6F, 1'b0, 1'b0);
    check("fullpp_count", 32'(count), 32'(D));
    check("fullpp_overflow", 32'(overflow), 32'd0);

    // Reset mid-run discards queued entries; capture restarts from scratch
    tick(7'h00, 1'b0, 1'b1);
    hold(7'h06, 6, 1'b0);
    hold(7'h5B, 6, 1'b0);
    hold(7'h4F, 6, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    tick(7'h4F, 1'b0, 1'b1);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_overflow", 32'(overflow), 32'd0);
    got.delete();
    hold(7'h7F, S + 1, 1'b1);
    hold(7'h00, 3, 1'b1);
    check("post_rst_n", 32'(got.size()), 32'd1);
    check("post_rst_entry", 32'(got_at(0)), 32'({7'h7F, 1'b0, 4'h8}));

    // Randomized patterns, hold lengths, consumer pressure and rare resets
    left = 0;
    cur  = 7'h00;
    for (int blk = 0; blk < 4; blk++) begin
      thr = (blk == 0) ? 10 : (blk == 1) ? 85 : (blk == 2) ? 40 : 95;
      for (int t = 0; t < 200; t++) begin
        if (left == 0) begin
          cur  = pool[$urandom_range(0, 18)];
          left = $urandom_range(1, 8);
        end
        left--;
        tick(cur, $urandom_range(0, 99) < thr, $urandom_range(0, 299) == 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
